hazard_ctrl: RTL and testbench

- Pipeline interlock controller for the 5-stage MIPS core; works alongside the operand forwarding path.
- Detects hazards that forwarding cannot resolve: load-use, HI/LO-after-multicycle-MDU, and data-memory wait.
- Resolves taken-branch control hazards.
- Drives hold/bubble/flush strobes to the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and keeps a stall-cycle counter.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_ctrl_if.sv | 48 ++++
 rtl/hazard_ctrl_mdu_busy_counter.sv | 26 ++
 rtl/hazard_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and FSM encoding for the pipeline interlock controller.
package hazard_pkg;

    localparam int REGADDR_WIDTH = 5;
    localparam int MDU_LATENCY   = 32;
    localparam int MDU_CNT_WIDTH = 6;

    typedef enum logic {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the interlock controller: hazard inputs from ID/EX/MEM
// and the hold/bubble/flush strobes back to the pipeline registers.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int REGADDR_WIDTH = hazard_pkg::REGADDR_WIDTH
);
    logic [REGADDR_WIDTH-1:0] id_rs_addr;
    logic [REGADDR_WIDTH-1:0] id_rt_addr;
    logic                     id_uses_rs;
    logic                     id_uses_rt;
    logic                     id_reads_hilo;
    logic [REGADDR_WIDTH-1:0] ex_wb_reg_addr;
    logic                     ex_is_load;
    logic                     ex_mdu_start;
    logic                     ex_branch_taken;
    logic                     mem_req;
    logic                     mem_ready;

    logic                     pc_hold;
    logic                     if2id_hold;
    logic                     if2id_flush;
    logic                     id2ex_hold;
    logic                     id2ex_bubble;
    logic                     ex2mem_hold;
    logic                     mem2wb_bubble;
    logic                     mdu_busy;
    logic [31:0]              stall_count;
    state_t                   fsm_state;

    // Strobes are level signals sampled by the pipeline registers on the
    // rising edge; there is no valid/ready handshake on this bus.
    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_reads_hilo,
               ex_wb_reg_addr, ex_is_load, ex_mdu_start, ex_branch_taken,
               mem_req, mem_ready,
        input  pc_hold, if2id_hold, if2id_flush, id2ex_hold, id2ex_bubble,
               ex2mem_hold, mem2wb_bubble, mdu_busy, stall_count, fsm_state
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_reads_hilo,
               ex_wb_reg_addr, ex_is_load, ex_mdu_start, ex_branch_taken,
               mem_req, mem_ready,
        output pc_hold, if2id_hold, if2id_flush, id2ex_hold, id2ex_bubble,
               ex2mem_hold, mem2wb_bubble, mdu_busy, stall_count, fsm_state
    );
endinterface

// File: rtl/hazard_ctrl_mdu_busy_counter.sv
// Tracks how long the multi-cycle mult/div unit stays busy after an issue.
module mdu_busy_counter #(
    parameter int LATENCY   = 32,
    parameter int CNT_WIDTH = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);
    logic [CNT_WIDTH-1:0] cnt;

    // The MDU runs on its own, so the count keeps falling even while the
    // pipeline is frozen; only the issue itself is gated by the caller.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_WIDTH'(LATENCY);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// Interlock controller for the 5-stage MIPS pipeline: load-use, HI/LO-after-MDU,
// data-memory wait and taken-branch flush, plus a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REGADDR_WIDTH = hazard_pkg::REGADDR_WIDTH,
    parameter int MDU_LATENCY   = hazard_pkg::MDU_LATENCY,
    parameter int MDU_CNT_WIDTH = hazard_pkg::MDU_CNT_WIDTH
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave bus
);
    state_t state, state_next;
    logic   freeze;
    logic   load_hit;
    logic   mdu_hit;
    logic   stall;
    logic   flush;
    logic   mdu_busy;
    logic   rs_match;
    logic   rt_match;

    assign freeze   = bus.mem_req & ~bus.mem_ready;
    assign rs_match = bus.id_uses_rs & (bus.id_rs_addr == bus.ex_wb_reg_addr);
    assign rt_match = bus.id_uses_rt & (bus.id_rt_addr == bus.ex_wb_reg_addr);
    assign load_hit = bus.ex_is_load & (bus.ex_wb_reg_addr != '0) & (rs_match | rt_match);
    assign mdu_hit  = bus.id_reads_hilo & (mdu_busy | bus.ex_mdu_start);

    mdu_busy_counter #(
        .LATENCY   (MDU_LATENCY),
        .CNT_WIDTH (MDU_CNT_WIDTH)
    ) u_mdu_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (bus.ex_mdu_start & ~freeze),
        .busy (mdu_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Load data is only forwardable from WB, so a hit costs two bubbles:
    // one here in RUN and one more unconditionally in LOAD_WAIT.
    always_comb begin
        state_next = state;
        stall      = mdu_hit;
        flush      = 1'b0;
        if (!freeze) begin
            flush = bus.ex_branch_taken;
            case (state)
                RUN: begin
                    if (load_hit) begin
                        stall      = 1'b1;
                        state_next = LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    stall      = 1'b1;
                    state_next = RUN;
                end
                default: state_next = RUN;
            endcase
        end
    end

    // Freeze holds every register and empties WB; any pending flush or bubble
    // re-appears after the freeze because the EX inputs are held with it.
    always_comb begin
        bus.pc_hold       = 1'b0;
        bus.if2id_hold    = 1'b0;
        bus.if2id_flush   = 1'b0;
        bus.id2ex_hold    = 1'b0;
        bus.id2ex_bubble  = 1'b0;
        bus.ex2mem_hold   = 1'b0;
        bus.mem2wb_bubble = 1'b0;
        if (freeze) begin
            bus.pc_hold       = 1'b1;
            bus.if2id_hold    = 1'b1;
            bus.id2ex_hold    = 1'b1;
            bus.ex2mem_hold   = 1'b1;
            bus.mem2wb_bubble = 1'b1;
        end else begin
            bus.pc_hold      = stall;
            bus.if2id_hold   = stall & ~flush;
            bus.if2id_flush  = flush;
            bus.id2ex_bubble = stall;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stall_count <= '0;
        end else if (bus.pc_hold && (bus.stall_count != 32'hFFFF_FFFF)) begin
            bus.stall_count <= bus.stall_count + 32'd1;
        end
    end

    assign bus.mdu_busy  = mdu_busy;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with a short MDU latency.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int LAT = 4;
    // Strobe vector order: pc_hold, if2id_hold, if2id_flush, id2ex_hold,
    // id2ex_bubble, ex2mem_hold, mem2wb_bubble.
    localparam logic [6:0] S_IDLE   = 7'b000_0000;
    localparam logic [6:0] S_STALL  = 7'b110_0100;
    localparam logic [6:0] S_FREEZE = 7'b110_1011;
    localparam logic [6:0] S_FLUSH  = 7'b001_0000;
    localparam logic [6:0] S_STFL   = 7'b101_0100;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    hazard_ctrl_if #(.REGADDR_WIDTH(5)) bus ();

    hazard_ctrl #(
        .REGADDR_WIDTH (5),
        .MDU_LATENCY   (LAT),
        .MDU_CNT_WIDTH (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wire [6:0] strobes = {bus.pc_hold, bus.if2id_hold, bus.if2id_flush, bus.id2ex_hold,
                          bus.id2ex_bubble, bus.ex2mem_hold, bus.mem2wb_bubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.id_rs_addr      = '0;
        bus.id_rt_addr      = '0;
        bus.id_uses_rs      = 1'b0;
        bus.id_uses_rt      = 1'b0;
        bus.id_reads_hilo   = 1'b0;
        bus.ex_wb_reg_addr  = '0;
        bus.ex_is_load      = 1'b0;
        bus.ex_mdu_start    = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_req         = 1'b0;
        bus.mem_ready       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_load_rs8();
        bus.ex_is_load     = 1'b1;
        bus.ex_wb_reg_addr = 5'd8;
        bus.id_rs_addr     = 5'd8;
        bus.id_uses_rs     = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (strobes !== S_IDLE) begin
            n_fail++; $display("FAIL reset_strobes got=%b exp=%b", strobes, S_IDLE);
        end
        n_checks++;
        if (bus.mdu_busy !== 1'b0 || bus.stall_count !== 32'd0 || bus.fsm_state !== RUN) begin
            n_fail++;
            $display("FAIL reset_state busy=%b cnt=%0d st=%b exp 0/0/RUN", bus.mdu_busy, bus.stall_count, bus.fsm_state);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk); set_load_rs8(); #1;
        n_checks++;
        if (strobes !== S_STALL) begin
            n_fail++; $display("FAIL load_use_c1 got=%b exp=%b", strobes, S_STALL);
        end
        // EX now holds the bubble inserted last cycle.
        @(negedge clk); bus.ex_is_load = 1'b0; #1;
        n_checks++;
        if (strobes !== S_STALL) begin
            n_fail++; $display("FAIL load_use_c2 got=%b exp=%b", strobes, S_STALL);
        end
        @(negedge clk); #1;
        n_checks++;
        if (strobes !== S_IDLE) begin
            n_fail++; $display("FAIL load_use_c3 got=%b exp=%b", strobes, S_IDLE);
        end
        n_checks++;
        if (bus.stall_count !== 32'd2) begin
            n_fail++; $display("FAIL load_use_count got=%0d exp=2", bus.stall_count);
        end
    endtask

    task automatic test_load_no_hit();
        do_reset();
        @(negedge clk);
        bus.ex_is_load = 1'b1; bus.ex_wb_reg_addr = 5'd0;
        bus.id_rt_addr = 5'd0; bus.id_uses_rt = 1'b1; #1;
        n_checks++;
        if (strobes !== S_IDLE) begin
            n_fail++; $display("FAIL load_r0 got=%b exp=%b", strobes, S_IDLE);
        end
        // Matching rt that the instruction does not read must not stall.
        @(negedge clk);
        bus.ex_wb_reg_addr = 5'd9; bus.id_rt_addr = 5'd9; bus.id_uses_rt = 1'b0;
        bus.id_rs_addr = 5'd3; bus.id_uses_rs = 1'b1; #1;
        n_checks++;
        if (strobes !== S_IDLE) begin
            n_fail++; $display("FAIL load_rt_unused got=%b exp=%b", strobes, S_IDLE);
        end
        @(negedge clk); bus.id_uses_rt = 1'b1; #1;
        n_checks++;
        if (strobes !== S_STALL) begin
            n_fail++; $display("FAIL load_rt_hit got=%b exp=%b", strobes, S_STALL);
        end
        @(negedge clk); idle_inputs(); #1;
        n_checks++;
        if (bus.stall_count !== 32'd1) begin
            n_fail++; $display("FAIL load_no_hit_count got=%0d exp=1", bus.stall_count);
        end
    endtask

    task automatic test_mdu();
        do_reset();
        @(negedge clk); bus.ex_mdu_start = 1'b1; #1;
        n_checks++;
        if (strobes !== S_IDLE || bus.mdu_busy !== 1'b0) begin
            n_fail++; $display("FAIL mdu_start got=%b busy=%b exp=%b busy=0", strobes, bus.mdu_busy, S_IDLE);
        end
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk); bus.ex_mdu_start = 1'b0; bus.id_reads_hilo = 1'b1; #1;
            n_checks++;
            if (strobes !== S_STALL || bus.mdu_busy !== 1'b1) begin
                n_fail++; $display("FAIL mdu_busy_c%0d got=%b busy=%b exp=%b busy=1", i, strobes, bus.mdu_busy, S_STALL);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (strobes !== S_IDLE || bus.mdu_busy !== 1'b0) begin
            n_fail++; $display("FAIL mdu_done got=%b busy=%b exp=%b busy=0", strobes, bus.mdu_busy, S_IDLE);
        end
        n_checks++;
        if (bus.stall_count !== 32'd4) begin
            n_fail++; $display("FAIL mdu_count got=%0d exp=4", bus.stall_count);
        end
        // Reading HI/LO in the issue cycle itself stalls too.
        @(negedge clk); bus.ex_mdu_start = 1'b1; #1;
        n_checks++;
        if (strobes !== S_STALL) begin
            n_fail++; $display("FAIL mdu_same_cycle got=%b exp=%b", strobes, S_STALL);
        end
        // Counter keeps running under freeze.
        @(negedge clk); bus.ex_mdu_start = 1'b0; bus.id_reads_hilo = 1'b0;
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 0; i < LAT - 1; i++) @(negedge clk);
        #1;
        n_checks++;
        if (bus.mdu_busy !== 1'b1) begin
            n_fail++; $display("FAIL mdu_freeze_last got=%b exp=1", bus.mdu_busy);
        end
        @(negedge clk); #1;
        n_checks++;
        if (bus.mdu_busy !== 1'b0) begin
            n_fail++; $display("FAIL mdu_freeze_done got=%b exp=0", bus.mdu_busy);
        end
        // An issue during freeze is not taken.
        bus.ex_mdu_start = 1'b1;
        @(negedge clk); bus.ex_mdu_start = 1'b0; bus.mem_req = 1'b0; #1;
        n_checks++;
        if (bus.mdu_busy !== 1'b0) begin
            n_fail++; $display("FAIL mdu_start_frozen got=%b exp=0", bus.mdu_busy);
        end
    endtask

    task automatic test_freeze_load();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set_load_rs8(); bus.mem_req = 1'b1; bus.mem_ready = 1'b0; #1;
            n_checks++;
            if (strobes !== S_FREEZE || bus.fsm_state !== RUN) begin
                n_fail++; $display("FAIL freeze_c%0d got=%b st=%b exp=%b st=RUN", i, strobes, bus.fsm_state, S_FREEZE);
            end
        end
        @(negedge clk); bus.mem_ready = 1'b1; #1;
        n_checks++;
        if (strobes !== S_STALL) begin
            n_fail++; $display("FAIL freeze_load_b1 got=%b exp=%b", strobes, S_STALL);
        end
        @(negedge clk); bus.ex_is_load = 1'b0; #1;
        n_checks++;
        if (strobes !== S_STALL) begin
            n_fail++; $display("FAIL freeze_load_b2 got=%b exp=%b", strobes, S_STALL);
        end
        @(negedge clk); #1;
        n_checks++;
        if (strobes !== S_IDLE || bus.stall_count !== 32'd5) begin
            n_fail++; $display("FAIL freeze_load_end got=%b cnt=%0d exp=%b cnt=5", strobes, bus.stall_count, S_IDLE);
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); bus.ex_branch_taken = 1'b1; bus.mem_req = 1'b1; bus.mem_ready = 1'b0; #1;
            n_checks++;
            if (strobes !== S_FREEZE) begin
                n_fail++; $display("FAIL branch_frozen_c%0d got=%b exp=%b", i, strobes, S_FREEZE);
            end
        end
        @(negedge clk); bus.mem_ready = 1'b1; #1;
        n_checks++;
        if (strobes !== S_FLUSH) begin
            n_fail++; $display("FAIL branch_released got=%b exp=%b", strobes, S_FLUSH);
        end
        // Flush wins IF/ID over a coincident load-use stall.
        @(negedge clk); bus.mem_req = 1'b0; set_load_rs8(); #1;
        n_checks++;
        if (strobes !== S_STFL) begin
            n_fail++; $display("FAIL branch_with_stall got=%b exp=%b", strobes, S_STFL);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk); bus.ex_mdu_start = 1'b1;
        @(negedge clk); bus.ex_mdu_start = 1'b0; set_load_rs8();
        @(negedge clk); idle_inputs(); #1;
        n_checks++;
        if (bus.fsm_state !== LOAD_WAIT || bus.mdu_busy !== 1'b1 || strobes !== S_STALL) begin
            n_fail++; $display("FAIL pre_reset st=%b busy=%b got=%b exp LOAD_WAIT/1/%b", bus.fsm_state, bus.mdu_busy, strobes, S_STALL);
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        n_checks++;
        if (strobes !== S_IDLE || bus.mdu_busy !== 1'b0 || bus.stall_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid got=%b busy=%b cnt=%0d exp=%b busy=0 cnt=0", strobes, bus.mdu_busy, bus.stall_count, S_IDLE);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_load_no_hit();
        test_mdu();
        test_freeze_load();
        test_branch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
